// File: rtl/infer_sdpram_be.sv
// Simple dual-port RAM with byte-lane writes, registered inputs, a read-valid
// strobe, an optional output register and a selectable read-during-write mode.
//
// Handshake: there is no back-pressure. A read is requested by holding en_b
// high for one cycle with addr_b. Each request is answered by exactly one
// rd_valid_b pulse, in request order, a fixed number of cycles later. A write
// is requested by en_a & write_a with at least one be_a bit set. There is no
// ready signal on either port.
module infer_sdpram_be #(
    parameter int DWIDTH  = 36,
    parameter int AWIDTH  = 10,
    parameter int BWIDTH  = 9,
    parameter int OUT_REG = 1,
    parameter int RD_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en_a,
    input  logic                       write_a,
    input  logic [DWIDTH/BWIDTH-1:0]   be_a,
    input  logic [DWIDTH-1:0]          wr_data_a,
    input  logic [AWIDTH-1:0]          addr_a,
    input  logic                       en_b,
    input  logic [AWIDTH-1:0]          addr_b,
    output logic [DWIDTH-1:0]          rd_data_b,
    output logic                       rd_valid_b
);

    localparam int NBYTE = DWIDTH / BWIDTH;
    localparam int DEPTH = 1 << AWIDTH;

    // Storage array; never reset so it maps onto block RAM.
    logic [DWIDTH-1:0] r_mem [DEPTH];

    // Stage-0 registers
    logic              r_en_a;
    logic              r_wr_a;
    logic [NBYTE-1:0]  r_be_a;
    logic [DWIDTH-1:0] r_wd_a;
    logic [AWIDTH-1:0] r_addr_a;
    logic              r_en_b;
    logic [AWIDTH-1:0] r_addr_b;

    // Stage-1 registers
    logic [DWIDTH-1:0] r_arr_q;
    logic              r_vld1;

    logic              w_wr_a;
    logic              w_coll;
    logic [DWIDTH-1:0] w_old;
    logic [DWIDTH-1:0] w_rd_word;

    // Stage 0: control bits are reset so a pending write or read is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_a <= 1'b0;
            r_wr_a <= 1'b0;
            r_be_a <= '0;
            r_en_b <= 1'b0;
        end else begin
            r_en_a <= en_a;
            r_wr_a <= write_a;
            r_be_a <= be_a;
            r_en_b <= en_b;
        end
    end

    // Stage 0: data and address registers need no reset.
    always_ff @(posedge clk) begin
        r_wd_a   <= wr_data_a;
        r_addr_a <= addr_a;
        r_addr_b <= addr_b;
    end

    assign w_wr_a = r_en_a & r_wr_a;
    assign w_coll = w_wr_a & (|r_be_a) & (r_addr_a == r_addr_b);
    assign w_old  = r_mem[r_addr_b];

    // Stage 1: byte-lane write into the array.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTE; i++) begin
            if (w_wr_a && r_be_a[i]) begin
                r_mem[r_addr_a][i*BWIDTH +: BWIDTH] <= r_wd_a[i*BWIDTH +: BWIDTH];
            end
        end
    end

    // Read word: old contents, or old contents merged with the colliding write.
    always_comb begin
        w_rd_word = w_old;
        if ((RD_MODE != 0) && w_coll) begin
            for (int i = 0; i < NBYTE; i++) begin
                if (r_be_a[i]) begin
                    w_rd_word[i*BWIDTH +: BWIDTH] = r_wd_a[i*BWIDTH +: BWIDTH];
                end
            end
        end
    end

    // Stage 1: array output register and first valid bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_arr_q <= '0;
            r_vld1  <= 1'b0;
        end else begin
            r_vld1 <= r_en_b;
            if (r_en_b) begin
                r_arr_q <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DWIDTH-1:0] r_dout;
            logic              r_vld2;

            // Stage 2: output register loads only on a valid read, so it holds.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_dout <= '0;
                    r_vld2 <= 1'b0;
                end else begin
                    r_vld2 <= r_vld1;
                    if (r_vld1) begin
                        r_dout <= r_arr_q;
                    end
                end
            end

            assign rd_data_b  = r_dout;
            assign rd_valid_b = r_vld2;
        end else begin : g_noreg
            assign rd_data_b  = r_arr_q;
            assign rd_valid_b = r_vld1;
        end
    endgenerate

endmodule

// File: tb/tb_infer_sdpram_be.sv
// Bench for infer_sdpram_be: two instances share stimulus, one with the output
// register and old-data collisions, one without and with merged collisions.
module tb_infer_sdpram_be;

    localparam int DW    = 36;
    localparam int AW    = 10;
    localparam int BW    = 9;
    localparam int NB    = 4;
    localparam int DEPTH = 1024;

    // Clock / reset
    logic          clk = 1'b0;
    logic          rst_n;
    always #5 clk = ~clk;

    logic          en_a;
    logic          write_a;
    logic [NB-1:0] be_a;
    logic [DW-1:0] wr_data_a;
    logic [AW-1:0] addr_a;
    logic          en_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] o0_data, o1_data;
    logic          o0_valid, o1_valid;

    infer_sdpram_be #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW), .OUT_REG(1), .RD_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en_a(en_a), .write_a(write_a), .be_a(be_a),
        .wr_data_a(wr_data_a), .addr_a(addr_a), .en_b(en_b), .addr_b(addr_b),
        .rd_data_b(o0_data), .rd_valid_b(o0_valid)
    );

    infer_sdpram_be #(.DWIDTH(DW), .AWIDTH(AW), .BWIDTH(BW), .OUT_REG(0), .RD_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en_a(en_a), .write_a(write_a), .be_a(be_a),
        .wr_data_a(wr_data_a), .addr_a(addr_a), .en_b(en_b), .addr_b(addr_b),
        .rd_data_b(o1_data), .rd_valid_b(o1_valid)
    );

    // Reference model: a word array, a write that lands one edge after it is
    // sampled, and per-instance expected-output queues of {valid, data}.
    logic [DW-1:0] mdl_mem [DEPTH];
    logic          pend_v;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic [NB-1:0] pend_be;
    logic [DW:0]   exp_q0[$];
    logic [DW:0]   exp_q1[$];
    logic [DW-1:0] last0, last1;
    logic          expv0, expv1;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            step_no  = 0;
    int            mark     = 0;
    logic          arm      = 1'b0;
    logic          got0, got1;
    logic [DW-1:0] cap0, cap1;
    int            lat0, lat1;
    logic          stream_on = 1'b0;
    logic [DW-1:0] sq0[$];
    logic [DW-1:0] sq1[$];

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_w,
                                                 input logic [DW-1:0] new_w,
                                                 input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[i*BW +: BW] = new_w[i*BW +: BW];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic model_clear();
        exp_q0.delete();
        exp_q1.delete();
        pend_v = 1'b0;
        last0  = '0;
        last1  = '0;
        expv0  = 1'b0;
        expv1  = 1'b0;
    endtask

    // Called once per rising edge with the inputs that edge sampled.
    task automatic model_edge();
        logic [DW-1:0] old_w, new_w;
        logic          wr_now;
        logic [DW:0]   e;
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (pend_v) mdl_mem[pend_addr] = lane_merge(mdl_mem[pend_addr], pend_data, pend_be);
        pend_v = 1'b0;
        wr_now = en_a && write_a && (be_a != '0);
        old_w  = mdl_mem[addr_b];
        new_w  = (wr_now && addr_a == addr_b) ? lane_merge(old_w, wr_data_a, be_a) : old_w;
        exp_q0.push_back({en_b, old_w});
        exp_q1.push_back({en_b, new_w});
        if (wr_now) begin
            pend_v    = 1'b1;
            pend_addr = addr_a;
            pend_data = wr_data_a;
            pend_be   = be_a;
        end
        expv0 = 1'b0;
        if (exp_q0.size() > 2) begin
            e     = exp_q0.pop_front();
            expv0 = e[DW];
            if (expv0) last0 = e[DW-1:0];
        end
        expv1 = 1'b0;
        if (exp_q1.size() > 1) begin
            e     = exp_q1.pop_front();
            expv1 = e[DW];
            if (expv1) last1 = e[DW-1:0];
        end
    endtask

    // Driver: one clock; scoreboard checks every instance at the falling edge.
    task automatic step();
        step_no++;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("valid0", {35'b0, o0_valid}, {35'b0, expv0});
        check("data0", o0_data, last0);
        check("valid1", {35'b0, o1_valid}, {35'b0, expv1});
        check("data1", o1_data, last1);
        if (arm) begin
            if (!got0 && o0_valid) begin
                got0 = 1'b1; cap0 = o0_data; lat0 = step_no - mark + 1;
            end
            if (!got1 && o1_valid) begin
                got1 = 1'b1; cap1 = o1_data; lat1 = step_no - mark + 1;
            end
        end
        if (stream_on) begin
            if (o0_valid) sq0.push_back(o0_data);
            if (o1_valid) sq1.push_back(o1_data);
        end
    endtask

    task automatic idle();
        en_a    = 1'b0;
        write_a = 1'b0;
        be_a    = '0;
        en_b    = 1'b0;
    endtask

    task automatic drive(input logic do_w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [NB-1:0] wbe, input logic do_r, input logic [AW-1:0] ra);
        en_a      = do_w;
        write_a   = do_w;
        be_a      = wbe;
        wr_data_a = wd;
        addr_a    = wa;
        en_b      = do_r;
        addr_b    = ra;
    endtask

    task automatic arm_capture();
        arm  = 1'b1;
        got0 = 1'b0; got1 = 1'b0;
        cap0 = '0;   cap1 = '0;
        lat0 = 0;    lat1 = 0;
        mark = step_no + 1;
    endtask

    task automatic write_only(input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic [NB-1:0] wbe);
        drive(1'b1, wa, wd, wbe, 1'b0, '0);
        step();
        idle();
    endtask

    // One read (optionally with a write in the same cycle), then a bounded wait.
    task automatic xact(input logic do_w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [NB-1:0] wbe, input logic [AW-1:0] ra);
        drive(do_w, wa, wd, wbe, 1'b1, ra);
        arm_capture();
        step();
        idle();
        repeat (4) step();
        arm = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        wr_data_a = '0;
        addr_a    = '0;
        addr_b    = '0;
        model_clear();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // Basic write then read; latency counts from the edge the request is launched on
        write_only(10'd5, 36'h123456789, 4'hF);
        xact(1'b0, '0, '0, '0, 10'd5);
        check("basic0_data", cap0, 36'h123456789);
        check("basic0_lat", DW'(lat0), 36'd3);
        check("basic1_data", cap1, 36'h123456789);
        check("basic1_lat", DW'(lat1), 36'd2);
        check("basic0_hold", o0_data, 36'h123456789);

        // Byte enables: lanes 0 and 2 cleared, lanes 1 and 3 keep 0x1FF
        write_only(10'd7, 36'hFFFFFFFFF, 4'hF);
        write_only(10'd7, 36'h000000000, 4'b0101);
        xact(1'b0, '0, '0, '0, 10'd7);
        check("be0_data", cap0, 36'hFF803FE00);
        check("be1_data", cap1, 36'hFF803FE00);

        // Same-cycle collision
        write_only(10'd3, 36'h0AAAAAAAA, 4'hF);
        xact(1'b1, 10'd3, 36'h155555555, 4'hF, 10'd3);
        check("coll0_old", cap0, 36'h0AAAAAAAA);
        check("coll1_new", cap1, 36'h155555555);
        xact(1'b0, '0, '0, '0, 10'd3);
        check("coll0_after", cap0, 36'h155555555);
        check("coll1_after", cap1, 36'h155555555);

        // Write followed by a read of the same address one cycle later
        write_only(10'd4, 36'h0F0F0F0F0, 4'hF);
        xact(1'b0, '0, '0, '0, 10'd4);
        check("raw0_data", cap0, 36'h0F0F0F0F0);
        check("raw1_data", cap1, 36'h0F0F0F0F0);

        // Streaming reads at full rate
        for (int i = 0; i < 16; i++) write_only(AW'(i), DW'(i * 3), 4'hF);
        sq0.delete();
        sq1.delete();
        stream_on = 1'b1;
        arm_capture();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, '0, '0, '0, 1'b1, AW'(i));
            step();
        end
        idle();
        repeat (5) step();
        stream_on = 1'b0;
        arm       = 1'b0;
        check("stream1_lat", DW'(lat1), 36'd2);
        check("stream0_lat", DW'(lat0), 36'd3);
        check("stream1_cnt", DW'(sq1.size()), 36'd16);
        check("stream0_cnt", DW'(sq0.size()), 36'd16);
        for (int i = 0; i < 16 && i < sq1.size(); i++) check("stream1_data", sq1[i], DW'(i * 3));
        for (int i = 0; i < 16 && i < sq0.size(); i++) check("stream0_data", sq0[i], DW'(i * 3));

        // Reset mid-operation, with a write still in stage 0
        drive(1'b0, '0, '0, '0, 1'b1, 10'd1);
        step();
        drive(1'b0, '0, '0, '0, 1'b1, 10'd2);
        step();
        drive(1'b1, 10'd1, 36'h0DEADBEEF, 4'hF, 1'b1, 10'd3);
        step();
        rst_n = 1'b0;
        model_clear();
        #1;
        check("rst_valid0", {35'b0, o0_valid}, 36'd0);
        check("rst_data0", o0_data, 36'd0);
        check("rst_valid1", {35'b0, o1_valid}, 36'd0);
        check("rst_data1", o1_data, 36'd0);
        idle();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        xact(1'b0, '0, '0, '0, 10'd1);
        check("rst0_keep", cap0, 36'd3);
        check("rst1_keep", cap1, 36'd3);

        // Address wrap: top and bottom locations are independent
        write_only(10'd1023, 36'hABCDE1234, 4'hF);
        xact(1'b0, '0, '0, '0, 10'd1023);
        check("wrap0_top", cap0, 36'hABCDE1234);
        check("wrap1_top", cap1, 36'hABCDE1234);
        xact(1'b0, '0, '0, '0, 10'd0);
        check("wrap0_bot", cap0, 36'd0);
        check("wrap1_bot", cap1, 36'd0);
        write_only(10'd0, 36'h012345678, 4'hF);
        xact(1'b0, '0, '0, '0, 10'd1023);
        check("wrap0_top2", cap0, 36'hABCDE1234);
        check("wrap1_top2", cap1, 36'hABCDE1234);

        // Randomized traffic over initialised addresses
        repeat (400) begin
            en_a      = 1'($urandom_range(0, 1));
            write_a   = 1'($urandom_range(0, 1));
            be_a      = NB'($urandom_range(0, 15));
            wr_data_a = {4'($urandom_range(0, 15)), 32'($urandom)};
            addr_a    = AW'($urandom_range(0, 15));
            en_b      = 1'($urandom_range(0, 1));
            addr_b    = AW'($urandom_range(0, 15));
            step();
        end
        idle();
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
